// File: rtl/text_vmem_scroll.sv
// Text-mode character store: write cursor, one-line hardware scroll and a
// registered character / glyph-offset read port for the VGA renderer.
module text_vmem_scroll #(
    parameter int COLS   = 70,
    parameter int ROWS   = 30,
    parameter int CHAR_W = 9,
    parameter int CHAR_H = 16,
    parameter int XW     = 7,
    parameter int YW     = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    key_in,
    input  logic          key_valid,
    output logic          key_ready,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic [9:0]    h_addr,
    input  logic [9:0]    v_addr,
    output logic [7:0]    ascii_out,
    output logic [3:0]    row,
    output logic [3:0]    col,
    output logic [XW-1:0] cursor_x,
    output logic [YW-1:0] cursor_y
);
    localparam int CELLS = COLS * ROWS;
    localparam int AW    = $clog2(CELLS);

    localparam logic [AW-1:0] LAST_CELL    = AW'(CELLS - 1);
    localparam logic [AW-1:0] LAST_COL_CNT = AW'(COLS - 1);
    localparam logic [XW-1:0] LAST_X       = XW'(COLS - 1);
    localparam logic [YW-1:0] LAST_Y       = YW'(ROWS - 1);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SCRUB = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [YW-1:0]   top_q, top_d;
    logic [XW-1:0]   cx_q, cx_d;
    logic [YW-1:0]   cy_q, cy_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            key_ready_q, key_ready_d;
    logic [7:0]      ascii_q, ascii_d;
    logic [3:0]      row_q, row_d;
    logic [3:0]      col_q, col_d;

    logic            we_s;
    logic [AW-1:0]   waddr_s;
    logic [7:0]      wdata_s;
    logic            do_nl_s;
    logic            rd_ok_s;
    logic [AW-1:0]   rd_addr_s;

    logic [7:0]      mem [CELLS];

    // Screen line is rotated by the scroll pointer to find the physical line.
    function automatic logic [AW-1:0] cell_addr(
        input logic [YW-1:0] line,
        input logic [YW-1:0] top,
        input logic [XW-1:0] cx
    );
        int p;
        p = int'(line) + int'(top);
        if (p >= ROWS) begin
            p = p - ROWS;
        end
        return AW'(p * COLS + int'(cx));
    endfunction

    // Read side: character lookup and glyph offsets, registered below.
    always_comb begin
        rd_ok_s   = ({1'b0, x} < (XW+1)'(COLS)) && ({1'b0, y} < (YW+1)'(ROWS));
        rd_addr_s = rd_ok_s ? cell_addr(y, top_q, x) : '0;
        ascii_d   = (rd_ok_s && (state_q != ST_CLEAR)) ? mem[rd_addr_s] : 8'h00;
        row_d     = 4'(v_addr - 10'(y) * 10'(CHAR_H));
        col_d     = 4'(h_addr - 10'(x) * 10'(CHAR_W));
    end

    // Control: clear sweep, key decode, newline/scroll and bottom-line scrub.
    always_comb begin
        state_d = state_q;
        top_d   = top_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        cnt_d   = cnt_q;
        we_s    = 1'b0;
        waddr_s = '0;
        wdata_s = 8'h00;
        do_nl_s = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                we_s    = 1'b1;
                waddr_s = cnt_q;
                if (cnt_q == LAST_CELL) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (key_valid && key_ready_q) begin
                    if ((key_in >= 8'h20) && (key_in <= 8'h7E)) begin
                        we_s    = 1'b1;
                        waddr_s = cell_addr(cy_q, top_q, cx_q);
                        wdata_s = key_in;
                        if (cx_q < LAST_X) begin
                            cx_d = cx_q + 1'b1;
                        end else begin
                            do_nl_s = 1'b1;
                        end
                    end else if (key_in == 8'h0A) begin
                        do_nl_s = 1'b1;
                    end else if (key_in == 8'h08) begin
                        // Backspace stays on the current line.
                        if (cx_q != '0) begin
                            cx_d    = cx_q - 1'b1;
                            we_s    = 1'b1;
                            waddr_s = cell_addr(cy_q, top_q, cx_q - 1'b1);
                        end else begin
                            cx_d = cx_q;
                        end
                    end else begin
                        we_s = 1'b0;
                    end
                end else begin
                    we_s = 1'b0;
                end
                if (do_nl_s) begin
                    cx_d = '0;
                    if (cy_q < LAST_Y) begin
                        cy_d = cy_q + 1'b1;
                    end else begin
                        top_d   = (top_q == LAST_Y) ? '0 : top_q + 1'b1;
                        state_d = ST_SCRUB;
                        cnt_d   = '0;
                    end
                end else begin
                    cy_d = cy_q;
                end
            end
            ST_SCRUB: begin
                we_s    = 1'b1;
                waddr_s = cell_addr(LAST_Y, top_q, XW'(cnt_q));
                if (cnt_q == LAST_COL_CNT) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
        key_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_CLEAR;
            top_q       <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            cnt_q       <= '0;
            key_ready_q <= 1'b0;
            ascii_q     <= 8'h00;
            row_q       <= 4'h0;
            col_q       <= 4'h0;
        end else begin
            state_q     <= state_d;
            top_q       <= top_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            cnt_q       <= cnt_d;
            key_ready_q <= key_ready_d;
            ascii_q     <= ascii_d;
            row_q       <= row_d;
            col_q       <= col_d;
        end
    end

    // Single write port; same-edge reads see the previous contents.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem[waddr_s] <= wdata_s;
        end
    end

    assign key_ready = key_ready_q;
    assign ascii_out = ascii_q;
    assign row       = row_q;
    assign col       = col_q;
    assign cursor_x  = cx_q;
    assign cursor_y  = cy_q;

endmodule

// File: tb/tb_text_vmem_scroll.sv
// Bench for text_vmem_scroll: screen-level model (rows shift on scroll) compared
// every quiet cycle, plus hand-computed directed checks.
module tb_text_vmem_scroll;
    localparam int COLS = 70, ROWS = 30, CHAR_W = 9, CHAR_H = 16, XW = 7, YW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    key_in;
    logic          key_valid;
    logic          key_ready;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [9:0]    h_addr, v_addr;
    logic [7:0]    ascii_out;
    logic [3:0]    row, col;
    logic [XW-1:0] cursor_x;
    logic [YW-1:0] cursor_y;

    int total = 0;
    int bad   = 0;

    logic [7:0] scr [ROWS][COLS];
    int  mx, my;
    bit  chk_en = 1'b0;
    bit  chk_q  = 1'b0;
    int  exp_a, exp_r, exp_c;

    text_vmem_scroll #(
        .COLS(COLS), .ROWS(ROWS), .CHAR_W(CHAR_W), .CHAR_H(CHAR_H), .XW(XW), .YW(YW)
    ) dut (
        .clk(clk), .reset(reset), .key_in(key_in), .key_valid(key_valid),
        .key_ready(key_ready), .x(x), .y(y), .h_addr(h_addr), .v_addr(v_addr),
        .ascii_out(ascii_out), .row(row), .col(col),
        .cursor_x(cursor_x), .cursor_y(cursor_y)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int model_rd(input int cx, input int cy);
        if (cx < COLS && cy < ROWS) return int'(scr[cy][cx]);
        return 0;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                scr[r][c] = 8'h00;
        mx = 0;
        my = 0;
    endtask

    task automatic model_key(input logic [7:0] k, output bit scrolled);
        bit nl;
        nl = 1'b0;
        scrolled = 1'b0;
        if (k >= 8'h20 && k <= 8'h7E) begin
            scr[my][mx] = k;
            if (mx < COLS - 1) mx++;
            else nl = 1'b1;
        end else if (k == 8'h0A) begin
            nl = 1'b1;
        end else if (k == 8'h08 && mx > 0) begin
            mx--;
            scr[my][mx] = 8'h00;
        end
        if (nl) begin
            mx = 0;
            if (my < ROWS - 1) begin
                my++;
            end else begin
                for (int r = 0; r < ROWS - 1; r++)
                    for (int c = 0; c < COLS; c++)
                        scr[r][c] = scr[r+1][c];
                for (int c = 0; c < COLS; c++)
                    scr[ROWS-1][c] = 8'h00;
                scrolled = 1'b1;
            end
        end
    endtask

    // Expected read-port values for whatever was presented at this edge.
    always @(posedge clk) begin
        chk_q <= chk_en;
        exp_a <= model_rd(int'(x), int'(y));
        exp_r <= (int'(v_addr) - int'(y) * CHAR_H) & 15;
        exp_c <= (int'(h_addr) - int'(x) * CHAR_W) & 15;
    end

    always @(negedge clk) begin
        if (chk_q) begin
            chk("ascii_out", int'(ascii_out), exp_a);
            chk("row", int'(row), exp_r);
            chk("col", int'(col), exp_c);
            chk("cursor_x", int'(cursor_x), mx);
            chk("cursor_y", int'(cursor_y), my);
            chk("key_ready_idle", int'(key_ready), 1);
        end
    end

    task automatic do_reset(input bit count_it);
        int lows;
        @(negedge clk);
        chk_en = 1'b0;
        reset = 1'b1;
        key_valid = 1'b1;
        key_in = 8'h51;
        repeat (2) @(negedge clk);
        chk("rst_key_ready", int'(key_ready), 0);
        chk("rst_ascii", int'(ascii_out), 0);
        chk("rst_row", int'(row), 0);
        chk("rst_col", int'(col), 0);
        chk("rst_cursor_x", int'(cursor_x), 0);
        chk("rst_cursor_y", int'(cursor_y), 0);
        model_clear();
        reset = 1'b0;
        if (count_it) begin
            lows = 0;
            while (!key_ready && lows < 5000) begin
                lows++;
                @(negedge clk);
            end
            chk("clear_busy_cycles", lows, 2100);
            key_valid = 1'b0;
            chk_en = 1'b1;
        end
    endtask

    task automatic send_key(input logic [7:0] k);
        int  w;
        int  busy;
        bit  scrolled;
        @(negedge clk);
        chk_en = 1'b0;
        w = 0;
        while (!key_ready && w < 500) begin
            w++;
            @(negedge clk);
        end
        chk("ready_before_key", int'(key_ready), 1);
        key_in = k;
        key_valid = 1'b1;
        @(negedge clk);
        model_key(k, scrolled);
        key_in = 8'h5A;
        busy = 0;
        while (!key_ready && busy < 500) begin
            busy++;
            @(negedge clk);
        end
        key_valid = 1'b0;
        chk("busy_after_key", busy, scrolled ? 70 : 0);
        chk_en = 1'b1;
    endtask

    task automatic rd_chk(input string nm, input int cx, input int cy, input int exp);
        @(negedge clk);
        x = XW'(cx);
        y = YW'(cy);
        @(negedge clk);
        chk(nm, int'(ascii_out), exp);
    endtask

    task automatic scan_all();
        for (int yy = 0; yy <= ROWS; yy++) begin
            for (int xx = 0; xx <= COLS; xx++) begin
                @(negedge clk);
                x = XW'(xx);
                y = YW'(yy);
                h_addr = 10'($urandom_range(0, 1023));
                v_addr = 10'($urandom_range(0, 1023));
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time budget, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        key_valid = 1'b0;
        key_in = 8'h00;
        x = '0;
        y = '0;
        h_addr = 10'd0;
        v_addr = 10'd0;
        model_clear();

        // Reset partway through the clear sweep must restart it from scratch.
        do_reset(1'b0);
        repeat (500) @(negedge clk);
        do_reset(1'b1);
        scan_all();

        send_key(8'h41);
        send_key(8'h42);
        chk("ab_cursor_x", int'(cursor_x), 2);
        chk("ab_cursor_y", int'(cursor_y), 0);
        rd_chk("ab_cell00", 0, 0, 8'h41);
        rd_chk("ab_cell10", 1, 0, 8'h42);

        do_reset(1'b1);
        repeat (70) send_key(8'h61);
        chk("full_cursor_x", int'(cursor_x), 0);
        chk("full_cursor_y", int'(cursor_y), 1);
        rd_chk("full_cell69", 69, 0, 8'h61);
        rd_chk("full_x70", 70, 0, 8'h00);
        send_key(8'h08);
        chk("bs_col0_cursor_x", int'(cursor_x), 0);
        chk("bs_col0_cursor_y", int'(cursor_y), 1);
        scan_all();

        do_reset(1'b1);
        send_key(8'h61);
        send_key(8'h62);
        send_key(8'h08);
        chk("bs_cursor_x", int'(cursor_x), 1);
        chk("bs_cursor_y", int'(cursor_y), 0);
        rd_chk("bs_cell10", 1, 0, 8'h00);
        rd_chk("bs_cell00", 0, 0, 8'h61);
        send_key(8'h1B);
        send_key(8'h7F);
        send_key(8'h80);
        chk("other_cursor_x", int'(cursor_x), 1);
        send_key(8'h0A);
        chk("enter_cursor_x", int'(cursor_x), 0);
        chk("enter_cursor_y", int'(cursor_y), 1);

        @(negedge clk);
        x = 7'd3;
        y = 5'd2;
        h_addr = 10'd30;
        v_addr = 10'd37;
        @(negedge clk);
        chk("offs_row", int'(row), 5);
        chk("offs_col", int'(col), 3);
        chk("offs_ascii", int'(ascii_out), 0);

        send_key(8'h78);
        send_key(8'h79);
        send_key(8'h7A);
        repeat (28) send_key(8'h0A);
        chk("bottom_cursor_y", int'(cursor_y), 29);
        send_key(8'h51);
        send_key(8'h0A);
        chk("scroll_cursor_x", int'(cursor_x), 0);
        chk("scroll_cursor_y", int'(cursor_y), 29);
        rd_chk("scroll_line0", 0, 0, 8'h78);
        rd_chk("scroll_line0_z", 2, 0, 8'h7A);
        rd_chk("scroll_line28", 0, 28, 8'h51);
        rd_chk("scroll_line29", 0, 29, 8'h00);
        scan_all();

        // Enough scrolls for the scroll pointer to wrap past the last line.
        for (int i = 0; i < 30; i++) begin
            send_key(8'(8'h30 + i % 10));
            send_key(8'h0A);
        end
        scan_all();

        // Wrapping at the last column of the bottom line also scrolls.
        for (int i = 0; i < 70; i++) begin
            send_key(8'(8'h21 + i));
        end
        chk("wrap_cursor_x", int'(cursor_x), 0);
        chk("wrap_cursor_y", int'(cursor_y), 29);
        rd_chk("wrap_line28_first", 0, 28, 8'h21);
        rd_chk("wrap_line28_last", 69, 28, 8'h66);
        scan_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
